fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch and memory-port sequencer that sits directly upstream of the single-port 16-bit RAM (512 words, synchronous 1-cycle read, synchronous write, no reset).
- Owns the PC and fetches one- or two-word instructions; a word with bit 15 set carries a 16-bit extension word at PC+1.
- Presents each assembled instruction to the decoder over a valid/ready handshake.
- Shares the RAM port with load/store requests from execute; data requests have priority whenever the port is idle.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- ADDR_W, 16, width of the PC and address path. The RAM decodes only the low 9 bits.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- mem_addr  out  16  RAM address (combinational from state, PC and dreq)
- mem_wdata  out  16  RAM write data
- mem_we  out  1  RAM write enable
- mem_rdata  in  16  RAM read data; valid the cycle after its address was driven
- redirect_valid  in  1  branch/jump redirect strobe
- redirect_pc  in  16  redirect target
- dreq_valid  in  1  data access request
- dreq_we  in  1  1 = store, 0 = load
- dreq_addr  in  16  data address
- dreq_wdata  in  16  store data
- dreq_ready  out  1  data request accepted this cycle
- drd_valid  out  1  one-cycle pulse: load data on drd_data
- drd_data  out  16  load result
- instr_valid  out  1  instruction held for decode
- instr_word  out  16  first instruction word
- instr_imm  out  16  extension word (0 for one-word instructions)
- instr_pc  out  16  address of instr_word
- instr_ready  in  1  decoder accepts instruction

Behaviour:
- Reset: one clock, clk; reset is asynchronous and active-low (rst_n).
  - On reset: pc=RESET_PC, state=S_ISSUE, drd_pending=0.
  - instr_valid, drd_valid, dreq_ready and mem_we are 0.
  - instr_word, instr_imm, instr_pc and drd_data are 0.
  - Reset mid-operation abandons any fetch or load with no pulse on drd_valid.
- States:
  - S_ISSUE: drive mem_addr=pc, mem_we=0, next S_W0.
  - S_W0: capture mem_rdata into instr_word and instr_pc<=pc.
    - If mem_rdata[15]=1: drive mem_addr=pc+1 this same cycle, next S_IMM.
    - Else: instr_imm<=0, pc<=pc+1, next S_HOLD.
  - S_IMM: instr_imm<=mem_rdata, pc<=pc+2, next S_HOLD.
  - S_HOLD: instr_valid=1. On instr_ready: next S_ISSUE. Held outputs are stable while instr_ready=0.
- Latency: instr_valid rises 2 cycles after S_ISSUE for a one-word instruction and 3 cycles for a two-word one. Back-to-back NOPs give one instruction every 3 cycles.
- Data port (S_ISSUE or S_HOLD only, i.e. port idle):
  - If dreq_valid: dreq_ready=1 combinationally; mem_addr=dreq_addr, mem_we=dreq_we, mem_wdata=dreq_wdata.
  - The state does not advance; a fetch in S_ISSUE is deferred one cycle.
  - Load: drd_pending<=1; the next cycle drd_valid=1 and drd_data=mem_rdata.
  - In S_W0 and S_IMM, dreq_ready=0.
- Redirect (any state, highest priority): pc<=redirect_pc, next S_ISSUE, instr_valid=0 from the next cycle.
  - An in-flight fetch word is discarded.
  - Redirect coinciding with instr_ready drops the held instruction; the decoder owns that case.
  - An accepted load still returns its drd_valid pulse.
- Arithmetic: pc+1 and pc+2 wrap modulo 2^16; 16'hFFFF+1 = 16'h0000. Extension fetch at 16'hFFFF reads address 0.
- mem_wdata is 0 whenever mem_we=0.

Decomposition:
- Shared package rgp16_pkg holds:
  - state enum S_ISSUE/S_W0/S_IMM/S_HOLD (2-bit)
  - ADDR_W/DATA_W constants
  - is_two_word(word) function returning bit 15
- No sub-module. The FSM and port mux fit in one module of about 200 lines.

Test Plan:
- Reset release, RAM preloaded with 0:A120, 1:007B, 2:0F00 -> instr_valid with word=A120, imm=007B, pc=0 at cycle 3; then word=0F00, imm=0, pc=2.
- instr_ready held 0 for 5 cycles while in S_HOLD -> outputs unchanged, no RAM fetch issued, pc stays 2.
- dreq load addr 10 (mem[10]=0F00) in S_ISSUE -> dreq_ready=1 that cycle, drd_valid pulse with 0F00 next cycle, fetch delayed exactly one cycle.
- dreq store 0x1234 to 13, then load 13 -> mem_we=1 for one cycle, load returns 1234.
- redirect_valid with pc=8 during S_IMM -> extension discarded, next instruction word=C132, imm=0040, pc=8.
- PC at FFFF holding a two-word instruction -> extension fetched from 0, next pc=0001; rst_n asserted mid-S_W0 -> all outputs 0 immediately.

Source files
------------

// File: rtl/rgp16_pkg.sv
// Shared types and helpers for the rgp16 fetch path: FSM state encoding,
// datapath widths and the instruction-length decode.
package rgp16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  typedef enum logic [1:0] {
    S_ISSUE = 2'd0,
    S_W0    = 2'd1,
    S_IMM   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  function automatic logic is_two_word(input logic [DATA_W-1:0] word);
    return word[15];
  endfunction

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: owns the PC, assembles one/two-word instructions
// from the single-port RAM and lets execute's load/store requests use the idle port.
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [rgp16_pkg::DATA_W-1:0] mem_wdata,
  output logic                         mem_we,
  input  logic [rgp16_pkg::DATA_W-1:0] mem_rdata,
  input  logic                         redirect_valid,
  input  logic [ADDR_W-1:0]            redirect_pc,
  input  logic                         dreq_valid,
  input  logic                         dreq_we,
  input  logic [ADDR_W-1:0]            dreq_addr,
  input  logic [rgp16_pkg::DATA_W-1:0] dreq_wdata,
  output logic                         dreq_ready,
  output logic                         drd_valid,
  output logic [rgp16_pkg::DATA_W-1:0] drd_data,
  output logic                         instr_valid,
  output logic [rgp16_pkg::DATA_W-1:0] instr_word,
  output logic [rgp16_pkg::DATA_W-1:0] instr_imm,
  output logic [ADDR_W-1:0]            instr_pc,
  input  logic                         instr_ready
);

  import rgp16_pkg::*;

  state_t            state, state_next;
  logic [ADDR_W-1:0] pc;
  logic              drd_pending;
  logic              port_idle;
  logic              data_go;

  // The RAM port is free whenever no fetch word is in flight.
  assign port_idle = (state == S_ISSUE) || (state == S_HOLD);
  assign data_go   = port_idle && dreq_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_ISSUE;
    end else begin
      state <= state_next;
    end
  end

  // A data access in S_HOLD does not stall the decode handshake; only the
  // fetch issue in S_ISSUE has to give way to it.
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = S_ISSUE;
    end else begin
      unique case (state)
        S_ISSUE: if (!data_go) state_next = S_W0;
        S_W0:    state_next = is_two_word(mem_rdata) ? S_IMM : S_HOLD;
        S_IMM:   state_next = S_HOLD;
        S_HOLD:  if (instr_ready) state_next = S_ISSUE;
        default: state_next = S_ISSUE;
      endcase
    end
  end

  always_comb begin
    dreq_ready  = data_go;
    mem_we      = data_go && dreq_we;
    mem_wdata   = mem_we ? dreq_wdata : '0;
    mem_addr    = pc;
    if (data_go) begin
      mem_addr = dreq_addr;
    end else if (state == S_W0) begin
      mem_addr = pc + ADDR_W'(1);
    end
    instr_valid = (state == S_HOLD);
    drd_valid   = drd_pending;
    drd_data    = drd_pending ? mem_rdata : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_word  <= '0;
      instr_imm   <= '0;
      instr_pc    <= '0;
      drd_pending <= 1'b0;
    end else begin
      drd_pending <= data_go && !dreq_we;
      if (redirect_valid) begin
        pc <= redirect_pc;
      end else begin
        unique case (state)
          S_W0: begin
            instr_word <= mem_rdata;
            instr_pc   <= pc;
            if (!is_two_word(mem_rdata)) begin
              instr_imm <= '0;
              pc        <= pc + ADDR_W'(1);
            end
          end
          S_IMM: begin
            instr_imm <= mem_rdata;
            pc        <= pc + ADDR_W'(2);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for fetch/handshake/data port,
// then hand sequences for redirect, PC wrap and mid-operation reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        dreq_valid, dreq_we;
  logic [15:0] dreq_addr, dreq_wdata;
  logic        dreq_ready, drd_valid;
  logic [15:0] drd_data;
  logic        instr_valid;
  logic [15:0] instr_word, instr_imm, instr_pc;
  logic        instr_ready;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .dreq_valid(dreq_valid), .dreq_we(dreq_we), .dreq_addr(dreq_addr), .dreq_wdata(dreq_wdata),
    .dreq_ready(dreq_ready), .drd_valid(drd_valid), .drd_data(drd_data),
    .instr_valid(instr_valid), .instr_word(instr_word), .instr_imm(instr_imm),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  // 512 x 16 RAM model: 1-cycle synchronous read, synchronous write, plus a
  // preload port the bench uses while the DUT is held in reset.
  logic [15:0] ram [0:511];
  logic        pl_en = 1'b0;
  logic [8:0]  pl_addr = '0;
  logic [15:0] pl_data = '0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr[8:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[8:0]];
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  typedef struct {
    logic rdy, dv, dwe; logic [15:0] daddr, dwd;
    logic iv; logic [15:0] iw, ii, ipc;
    logic dr, drv; logic [15:0] drd;
    logic we; logic [15:0] addr, wd;
  } vec_t;

  vec_t vec [19];

  typedef struct { logic [8:0] a; logic [15:0] d; } pl_t;
  pl_t pl [11];

  initial begin
    int cnt;
    rst_n = 1'b0; redirect_valid = 0; redirect_pc = '0; instr_ready = 0;
    dreq_valid = 0; dreq_we = 0; dreq_addr = '0; dreq_wdata = '0;

    pl[0]  = '{9'h000, 16'hA120}; pl[1] = '{9'h001, 16'h007B}; pl[2] = '{9'h002, 16'h0F00};
    pl[3]  = '{9'h003, 16'h0001}; pl[4] = '{9'h004, 16'h0000}; pl[5] = '{9'h005, 16'h8111};
    pl[6]  = '{9'h006, 16'h2222}; pl[7] = '{9'h008, 16'hC132}; pl[8] = '{9'h009, 16'h0040};
    pl[9]  = '{9'h00A, 16'h0F00}; pl[10] = '{9'h1FF, 16'h9ABC};

    //          rdy dv dwe daddr     dwd       iv iw        ii        ipc       dr drv drd       we addr      wd
    vec[0]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vec[1]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0001, 16'h0000};
    vec[2]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'hA120, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 16'h0000, 16'h0000};
    vec[3]  = '{1, 0, 0, 16'h0000, 16'h0000, 1, 16'hA120, 16'h007B, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 16'h0000};
    vec[4]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'hA120, 16'h007B, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 16'h0000};
    vec[5]  = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'hA120, 16'h007B, 16'h0000, 0, 0, 16'h0000, 0, 16'h0003, 16'h0000};
    for (int i = 6; i <= 10; i++)
      vec[i] = '{0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0F00, 16'h0000, 16'h0002, 0, 0, 16'h0000, 0, 16'h0003, 16'h0000};
    vec[11] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0F00, 16'h0000, 16'h0002, 0, 0, 16'h0000, 0, 16'h0003, 16'h0000};
    vec[12] = '{0, 1, 0, 16'h000A, 16'h5555, 0, 16'h0F00, 16'h0000, 16'h0002, 1, 0, 16'h0000, 0, 16'h000A, 16'h0000};
    vec[13] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0F00, 16'h0000, 16'h0002, 0, 1, 16'h0F00, 0, 16'h0003, 16'h0000};
    vec[14] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0F00, 16'h0000, 16'h0002, 0, 0, 16'h0000, 0, 16'h0004, 16'h0000};
    vec[15] = '{0, 1, 1, 16'h000D, 16'h1234, 1, 16'h0001, 16'h0000, 16'h0003, 1, 0, 16'h0000, 1, 16'h000D, 16'h1234};
    vec[16] = '{0, 1, 0, 16'h000D, 16'hFFFF, 1, 16'h0001, 16'h0000, 16'h0003, 1, 0, 16'h0000, 0, 16'h000D, 16'h0000};
    vec[17] = '{1, 0, 0, 16'h0000, 16'h0000, 1, 16'h0001, 16'h0000, 16'h0003, 0, 1, 16'h1234, 0, 16'h0004, 16'h0000};
    vec[18] = '{0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0001, 16'h0000, 16'h0003, 0, 0, 16'h0000, 0, 16'h0004, 16'h0000};

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_addr = pl[i].a; pl_data = pl[i].d;
    end
    @(negedge clk);
    pl_en = 1'b0;
    #1;
    chk("rst instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst drd_valid",   {15'd0, drd_valid},   16'd0);
    chk("rst dreq_ready",  {15'd0, dreq_ready},  16'd0);
    chk("rst mem_we",      {15'd0, mem_we},      16'd0);
    chk("rst instr_word",  instr_word, 16'h0000);
    chk("rst instr_imm",   instr_imm,  16'h0000);
    chk("rst instr_pc",    instr_pc,   16'h0000);
    chk("rst drd_data",    drd_data,   16'h0000);

    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 19; i++) begin
      instr_ready = vec[i].rdy; dreq_valid = vec[i].dv; dreq_we = vec[i].dwe;
      dreq_addr = vec[i].daddr; dreq_wdata = vec[i].dwd;
      #1;
      chk($sformatf("c%0d instr_valid", i), {15'd0, instr_valid}, {15'd0, vec[i].iv});
      chk($sformatf("c%0d instr_word", i),  instr_word, vec[i].iw);
      chk($sformatf("c%0d instr_imm", i),   instr_imm,  vec[i].ii);
      chk($sformatf("c%0d instr_pc", i),    instr_pc,   vec[i].ipc);
      chk($sformatf("c%0d dreq_ready", i),  {15'd0, dreq_ready}, {15'd0, vec[i].dr});
      chk($sformatf("c%0d drd_valid", i),   {15'd0, drd_valid},  {15'd0, vec[i].drv});
      chk($sformatf("c%0d drd_data", i),    drd_data,  vec[i].drd);
      chk($sformatf("c%0d mem_we", i),      {15'd0, mem_we}, {15'd0, vec[i].we});
      chk($sformatf("c%0d mem_addr", i),    mem_addr,  vec[i].addr);
      chk($sformatf("c%0d mem_wdata", i),   mem_wdata, vec[i].wd);
      @(negedge clk);
    end
    instr_ready = 0; dreq_valid = 0; dreq_we = 0; dreq_addr = '0; dreq_wdata = '0;

    // Redirect during S_W0 to 5 (two-word 8111), then again during S_IMM to 8.
    redirect_valid = 1; redirect_pc = 16'h0005;
    #1 chk("rdw0 instr_valid", {15'd0, instr_valid}, 16'd0);
    @(negedge clk); redirect_valid = 0;
    #1 chk("rd5 issue addr", mem_addr, 16'h0005);
    @(negedge clk);
    #1 chk("rd5 ext addr", mem_addr, 16'h0006);
    @(negedge clk);
    redirect_valid = 1; redirect_pc = 16'h0008;
    #1 chk("rdimm instr_valid", {15'd0, instr_valid}, 16'd0);
    @(negedge clk); redirect_valid = 0;
    #1 chk("rd8 instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("rd8 issue addr", mem_addr, 16'h0008);
    cnt = 0;
    while (!instr_valid && cnt < 8) begin
      @(negedge clk); #1; cnt++;
    end
    chk("rd8 latency", 16'(cnt), 16'd3);
    chk("rd8 instr_word", instr_word, 16'hC132);
    chk("rd8 instr_imm",  instr_imm,  16'h0040);
    chk("rd8 instr_pc",   instr_pc,   16'h0008);

    // Two-word instruction at FFFF: extension wraps to address 0.
    redirect_valid = 1; redirect_pc = 16'hFFFF;
    @(negedge clk); redirect_valid = 0;
    #1 chk("wrap issue addr", mem_addr, 16'hFFFF);
    chk("wrap instr_valid", {15'd0, instr_valid}, 16'd0);
    @(negedge clk);
    #1 chk("wrap ext addr", mem_addr, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    #1 chk("wrap instr_valid hold", {15'd0, instr_valid}, 16'd1);
    chk("wrap instr_word", instr_word, 16'h9ABC);
    chk("wrap instr_imm",  instr_imm,  16'hA120);
    chk("wrap instr_pc",   instr_pc,   16'hFFFF);
    instr_ready = 1;
    @(negedge clk); instr_ready = 0;
    #1 chk("wrap next pc", mem_addr, 16'h0001);
    @(negedge clk);
    #1 chk("w0 addr pre-reset", mem_addr, 16'h0002);

    // Asynchronous reset in S_W0 clears everything without a clock edge.
    rst_n = 1'b0;
    #1;
    chk("arst instr_valid", {15'd0, instr_valid}, 16'd0);
    chk("arst instr_word",  instr_word, 16'h0000);
    chk("arst instr_imm",   instr_imm,  16'h0000);
    chk("arst instr_pc",    instr_pc,   16'h0000);
    chk("arst mem_addr",    mem_addr,   16'h0000);
    chk("arst drd_valid",   {15'd0, drd_valid}, 16'd0);

    // An accepted load abandoned by reset never pulses drd_valid.
    @(negedge clk); rst_n = 1'b1;
    dreq_valid = 1; dreq_we = 0; dreq_addr = 16'h000A;
    #1 chk("ld dreq_ready", {15'd0, dreq_ready}, 16'd1);
    @(negedge clk); dreq_valid = 0; rst_n = 1'b0;
    #1 chk("ld abandoned drd_valid", {15'd0, drd_valid}, 16'd0);
    chk("ld abandoned drd_data", drd_data, 16'h0000);
    @(negedge clk); rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
